roce_tx_scheduler: RTL and testbench

- Sits between the UDP RoCE connection manager and the RoCE TX engine.
- Captures each metadata record into a per-QP context table and queues transfer requests in a small FIFO.
- Issues transfers one at a time, splitting each DMA into messages of at most MAX_MSG_SIZE bytes.
- Advances the remote address and local PSN per message, and waits for TX-engine completion before issuing the next.

---
 rtl/roce_sched_pkg.sv | 42 ++++
 rtl/roce_sched_fifo.sv | 44 ++++
 rtl/roce_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_roce_tx_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/roce_sched_pkg.sv
// Shared types for the RoCE TX scheduler: FSM encoding, QP context record,
// pending-request layout and the PSN-advance helper.
package roce_sched_pkg;

  localparam int QPN_W  = 24;
  localparam int PSN_W  = 24;
  localparam int RKEY_W = 32;
  localparam int IP_W   = 32;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [QPN_W-1:0]  rem_qpn;
    logic [PSN_W-1:0]  rem_psn;
    logic [PSN_W-1:0]  loc_psn;
    logic [RKEY_W-1:0] r_key;
  } qp_ctx_t;

  // FIFO entry is {qp index, req_body_t}; the index width depends on the table depth.
  typedef struct packed {
    logic [IP_W-1:0]   rem_ip;
    logic [ADDR_W-1:0] rem_addr;
    logic [LEN_W-1:0]  dma_length;
  } req_body_t;

  function automatic logic [PSN_W-1:0] ceil_div_pow2(input logic [LEN_W-1:0] len,
                                                     input int unsigned  sh);
    logic [LEN_W-1:0] mask;
    logic [LEN_W-1:0] quo;
    mask = (LEN_W'(1) << sh) - LEN_W'(1);
    quo  = (len >> sh) + LEN_W'(|(len & mask));
    return quo[PSN_W-1:0];
  endfunction

endpackage

// File: rtl/roce_sched_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken when a pop frees a slot on the same edge.
module roce_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/roce_tx_scheduler.sv
// RoCE TX scheduler: stores per-QP contexts, queues transfer requests and issues
// them one message at a time to the TX engine, waiting for completion between messages.
module roce_tx_scheduler
  import roce_sched_pkg::*;
#(
  parameter int          QP_TABLE_DEPTH = 4,
  parameter int          REQ_FIFO_DEPTH = 4,
  parameter logic [31:0] MAX_MSG_SIZE   = 32'h0001_0000,
  parameter logic [15:0] PMTU           = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_meta_valid,
  output logic        s_meta_ready,
  input  logic        s_qp_valid,
  input  logic        s_tx_valid,
  input  logic        s_tx_start,
  input  logic [23:0] s_loc_qpn,
  input  logic [23:0] s_rem_qpn,
  input  logic [23:0] s_rem_psn,
  input  logic [23:0] s_loc_psn,
  input  logic [31:0] s_r_key,
  input  logic [31:0] s_rem_ip_addr,
  input  logic [63:0] s_rem_addr,
  input  logic [31:0] s_dma_length,
  output logic        m_msg_valid,
  input  logic        m_msg_ready,
  output logic [23:0] m_msg_rem_qpn,
  output logic [23:0] m_msg_psn,
  output logic [31:0] m_msg_r_key,
  output logic [31:0] m_msg_rem_ip_addr,
  output logic [63:0] m_msg_rem_addr,
  output logic [31:0] m_msg_length,
  output logic        m_msg_last,
  input  logic        s_msg_done,
  output logic        busy,
  output logic        err_no_qp,
  output logic        err_overflow
);

  localparam int IDX_W   = $clog2(QP_TABLE_DEPTH);
  localparam int ENT_W   = IDX_W + $bits(req_body_t);
  localparam int PMTU_SH = $clog2(PMTU);

  sched_state_e               state, state_nxt;
  qp_ctx_t                    ctx_tbl [QP_TABLE_DEPTH];
  logic [QP_TABLE_DEPTH-1:0]  ctx_vld;
  qp_ctx_t                    ctx_rd;

  logic [IDX_W-1:0]  w_idx;
  logic [IP_W-1:0]   w_ip;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_rem;
  logic [QPN_W-1:0]  w_qpn;
  logic [PSN_W-1:0]  w_psn;
  logic [RKEY_W-1:0] w_rkey;

  logic [LEN_W-1:0]  msg_len;
  logic              msg_last;
  logic [PSN_W-1:0]  psn_nxt;
  logic              msg_done_acc;

  logic              accept, enq;
  logic [IDX_W-1:0]  wr_idx;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_din, fifo_dout;
  req_body_t         pop_body;

  assign accept   = s_meta_valid && s_meta_ready;
  assign wr_idx   = s_loc_qpn[IDX_W-1:0];
  assign enq      = accept && s_tx_valid && s_tx_start && (s_dma_length != '0);
  assign fifo_din = {wr_idx, req_body_t'{rem_ip: s_rem_ip_addr, rem_addr: s_rem_addr,
                                         dma_length: s_dma_length}};
  assign fifo_pop = (state == S_IDLE) && !fifo_empty;
  assign pop_body = req_body_t'(fifo_dout[ENT_W-IDX_W-1:0]);

  assign err_overflow = enq && fifo_full && !fifo_pop;
  assign busy         = (state != S_IDLE) || !fifo_empty;

  roce_sched_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ctx_rd       = ctx_tbl[w_idx];
  assign msg_last     = (w_rem <= MAX_MSG_SIZE);
  assign msg_len      = msg_last ? w_rem : MAX_MSG_SIZE;
  assign psn_nxt      = w_psn + ceil_div_pow2(msg_len, PMTU_SH);
  assign msg_done_acc = (state == S_WAIT) && s_msg_done;

  always_comb begin
    state_nxt   = state;
    m_msg_valid = 1'b0;
    err_no_qp   = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!ctx_vld[w_idx]) begin
          err_no_qp = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_msg_valid = 1'b1;
        if (m_msg_ready) state_nxt = S_WAIT;
      end
      S_WAIT:  if (s_msg_done) state_nxt = (w_rem == msg_len) ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Descriptor fields read as zero whenever no descriptor is offered, including reset.
  assign m_msg_rem_qpn     = m_msg_valid ? w_qpn   : '0;
  assign m_msg_psn         = m_msg_valid ? w_psn   : '0;
  assign m_msg_r_key       = m_msg_valid ? w_rkey  : '0;
  assign m_msg_rem_ip_addr = m_msg_valid ? w_ip    : '0;
  assign m_msg_rem_addr    = m_msg_valid ? w_addr  : '0;
  assign m_msg_length      = m_msg_valid ? msg_len : '0;
  assign m_msg_last        = m_msg_valid && msg_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      s_meta_ready <= 1'b0;
      ctx_vld      <= '0;
    end else begin
      state        <= state_nxt;
      s_meta_ready <= 1'b1;
      if (accept && s_qp_valid) ctx_vld[wr_idx] <= 1'b1;
    end
  end

  // A record write to the same QP on the completion edge takes priority.
  always_ff @(posedge clk) begin
    if (msg_done_acc) ctx_tbl[w_idx].loc_psn <= psn_nxt;
    if (accept && s_qp_valid)
      ctx_tbl[wr_idx] <= '{rem_qpn: s_rem_qpn, rem_psn: s_rem_psn,
                           loc_psn: s_loc_psn, r_key: s_r_key};
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      w_idx  <= fifo_dout[ENT_W-1 -: IDX_W];
      w_ip   <= pop_body.rem_ip;
      w_addr <= pop_body.rem_addr;
      w_rem  <= pop_body.dma_length;
    end
    if (state == S_LOAD) begin
      w_qpn  <= ctx_rd.rem_qpn;
      w_psn  <= ctx_rd.loc_psn;
      w_rkey <= ctx_rd.r_key;
    end
    if (msg_done_acc) begin
      w_addr <= w_addr + ADDR_W'(msg_len);
      w_rem  <= w_rem - msg_len;
      w_psn  <= psn_nxt;
    end
  end

endmodule

// File: tb/tb_roce_tx_scheduler.sv
// Scoreboard bench for roce_tx_scheduler: expected descriptors are queued as
// requests are driven and compared field by field at each descriptor handshake.
module tb_roce_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_meta_valid = 1'b0, s_meta_ready;
  logic        s_qp_valid = 1'b0, s_tx_valid = 1'b0, s_tx_start = 1'b0;
  logic [23:0] s_loc_qpn = '0, s_rem_qpn = '0, s_rem_psn = '0, s_loc_psn = '0;
  logic [31:0] s_r_key = '0, s_rem_ip_addr = '0, s_dma_length = '0;
  logic [63:0] s_rem_addr = '0;
  logic        m_msg_valid, m_msg_ready = 1'b1;
  logic [23:0] m_msg_rem_qpn, m_msg_psn;
  logic [31:0] m_msg_r_key, m_msg_rem_ip_addr, m_msg_length;
  logic [63:0] m_msg_rem_addr;
  logic        m_msg_last;
  logic        s_msg_done = 1'b0;
  logic        busy, err_no_qp, err_overflow;

  roce_tx_scheduler dut (
    .clk (clk), .rst (rst),
    .s_meta_valid (s_meta_valid), .s_meta_ready (s_meta_ready),
    .s_qp_valid (s_qp_valid), .s_tx_valid (s_tx_valid), .s_tx_start (s_tx_start),
    .s_loc_qpn (s_loc_qpn), .s_rem_qpn (s_rem_qpn), .s_rem_psn (s_rem_psn),
    .s_loc_psn (s_loc_psn), .s_r_key (s_r_key), .s_rem_ip_addr (s_rem_ip_addr),
    .s_rem_addr (s_rem_addr), .s_dma_length (s_dma_length),
    .m_msg_valid (m_msg_valid), .m_msg_ready (m_msg_ready),
    .m_msg_rem_qpn (m_msg_rem_qpn), .m_msg_psn (m_msg_psn),
    .m_msg_r_key (m_msg_r_key), .m_msg_rem_ip_addr (m_msg_rem_ip_addr),
    .m_msg_rem_addr (m_msg_rem_addr), .m_msg_length (m_msg_length),
    .m_msg_last (m_msg_last), .s_msg_done (s_msg_done),
    .busy (busy), .err_no_qp (err_no_qp), .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] qpn;
    logic [23:0] psn;
    logic [31:0] rkey;
    logic [31:0] ip;
    logic [63:0] addr;
    logic [31:0] len;
    logic        last;
  } desc_t;

  desc_t sb[$];
  int cmp_cnt = 0, mis_cnt = 0;
  int hs_cnt = 0, nq_cnt = 0, ov_cnt = 0, vld_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    desc_t e;
    if (rst) begin
      if (m_msg_valid)  vld_cnt++;
      if (err_no_qp)    nq_cnt++;
      if (err_overflow) ov_cnt++;
      if (m_msg_valid && m_msg_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_desc", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("desc_qpn",  m_msg_rem_qpn,     e.qpn);
          chk("desc_psn",  m_msg_psn,         e.psn);
          chk("desc_rkey", m_msg_r_key,       e.rkey);
          chk("desc_ip",   m_msg_rem_ip_addr, e.ip);
          chk("desc_addr", m_msg_rem_addr,    e.addr);
          chk("desc_len",  m_msg_length,      e.len);
          chk("desc_last", m_msg_last,        e.last);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Context fields and remote IP are derived from the QPN so expectations can be rebuilt.
  task automatic send(input logic qp, input logic tx, input logic [23:0] qpn,
                      input logic [23:0] lpsn, input logic [63:0] addr, input logic [31:0] len);
    s_meta_valid  = 1'b1;
    s_qp_valid    = qp;
    s_tx_valid    = tx;
    s_tx_start    = tx;
    s_loc_qpn     = qpn;
    s_rem_qpn     = qpn + 24'hABC000;
    s_rem_psn     = 24'h000005;
    s_loc_psn     = lpsn;
    s_r_key       = 32'hCAFE_0000 | {8'h0, qpn};
    s_rem_ip_addr = 32'h0A00_0000 | {8'h0, qpn};
    s_rem_addr    = addr;
    s_dma_length  = len;
    tick();
    s_meta_valid = 1'b0;
    s_qp_valid   = 1'b0;
    s_tx_valid   = 1'b0;
    s_tx_start   = 1'b0;
  endtask

  task automatic expect_desc(input logic [23:0] qpn, input logic [23:0] psn,
                             input logic [63:0] addr, input logic [31:0] len, input logic last);
    desc_t d;
    d.qpn  = qpn + 24'hABC000;
    d.psn  = psn;
    d.rkey = 32'hCAFE_0000 | {8'h0, qpn};
    d.ip   = 32'h0A00_0000 | {8'h0, qpn};
    d.addr = addr;
    d.len  = len;
    d.last = last;
    sb.push_back(d);
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("hs_count_wait", hs_cnt, target);
  endtask

  task automatic done_pulse();
    s_msg_done = 1'b1;
    tick();
    s_msg_done = 1'b0;
  endtask

  initial begin
    int vld_snap;
    #1 rst = 1'b0;
    #1;
    chk("rst_meta_ready", s_meta_ready, 0);
    chk("rst_msg_valid",  m_msg_valid,  0);
    chk("rst_busy",       busy,         0);
    chk("rst_err_no_qp",  err_no_qp,    0);
    chk("rst_err_ovf",    err_overflow, 0);
    tick(2);
    rst = 1'b1;
    chk("ready_before_edge", s_meta_ready, 0);
    tick();
    chk("ready_after_edge", s_meta_ready, 1);

    // Context write and transfer in one record: request must see the new context.
    expect_desc(24'd1, 24'h000010, 64'h1000, 32'd8192, 1'b1);
    send(1'b1, 1'b1, 24'd1, 24'h000010, 64'h1000, 32'd8192);
    wait_hs(1);
    done_pulse();

    // Split into two messages; PSN continues from the previous transfer.
    expect_desc(24'd1, 24'h000012, 64'h1000,  32'h10000, 1'b0);
    expect_desc(24'd1, 24'h000022, 64'h11000, 32'h8000,  1'b1);
    send(1'b0, 1'b1, 24'd1, 24'h0, 64'h1000, 32'h18000);
    wait_hs(2);
    done_pulse();
    wait_hs(3);
    done_pulse();

    // PSN wrap at 2^24.
    expect_desc(24'd2, 24'hFFFFFF, 64'hFFFF_FFFF_FFFF_F000, 32'd4097, 1'b1);
    send(1'b1, 1'b1, 24'd2, 24'hFFFFFF, 64'hFFFF_FFFF_FFFF_F000, 32'd4097);
    wait_hs(4);
    done_pulse();
    expect_desc(24'd2, 24'h000001, 64'h0, 32'd1, 1'b1);
    send(1'b0, 1'b1, 24'd2, 24'h0, 64'h0, 32'd1);
    wait_hs(5);
    done_pulse();

    // Zero-length request is silently ignored.
    tick(2);
    send(1'b0, 1'b1, 24'd1, 24'h0, 64'h3000, 32'd0);
    tick(3);
    chk("zero_len_busy", busy,   0);
    chk("zero_len_hs",   hs_cnt, 5);

    // Unwritten context.
    vld_snap = vld_cnt;
    send(1'b0, 1'b1, 24'd3, 24'h0, 64'h4000, 32'd64);
    tick(4);
    chk("no_qp_pulse",  nq_cnt,  1);
    chk("no_qp_no_vld", vld_cnt, vld_snap);
    chk("no_qp_idle",   busy,    0);

    // Fill the FIFO behind a stalled descriptor.
    m_msg_ready = 1'b0;
    expect_desc(24'd1, 24'h00002A, 64'h2000, 32'd100, 1'b1);
    repeat (5) send(1'b0, 1'b1, 24'd1, 24'h0, 64'h2000, 32'd100);
    chk("fifo_fill_no_ovf", ov_cnt, 0);
    send(1'b0, 1'b1, 24'd1, 24'h0, 64'h2000, 32'd100);
    chk("fifo_ovf_pulse", ov_cnt, 1);
    chk("fifo_busy",      busy,   1);
    m_msg_ready = 1'b1;
    wait_hs(6);

    // Asynchronous reset in WAIT.
    tick();
    #3 rst = 1'b0;
    #1;
    chk("midrst_meta_ready", s_meta_ready, 0);
    chk("midrst_busy",       busy,         0);
    chk("midrst_msg_valid",  m_msg_valid,  0);
    chk("midrst_msg_len",    m_msg_length, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", s_meta_ready, 1);
    chk("post_rst_busy",  busy,         0);
    vld_snap = vld_cnt;
    done_pulse();
    tick(5);
    chk("stray_done_hs",  hs_cnt,  6);
    chk("stray_done_vld", vld_cnt, vld_snap);
    chk("stray_done_busy", busy,   0);

    // Table valid bits were cleared by reset.
    send(1'b0, 1'b1, 24'd1, 24'h0, 64'h5000, 32'd16);
    tick(4);
    chk("post_rst_no_qp", nq_cnt, 2);
    chk("sb_drained",     sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
